// File: rtl/mem_pkg.sv
// Shared widths and the response record used by
// the memory responder and its response FIFO.
package mem_pkg;

    localparam int LATENCY = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int WORDS   = 32768;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO with clear, count and
// full/empty flags; head is visible combinationally.
module rsp_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  rsp_t          din,
    input  logic          pop,
    output rsp_t          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; clear empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Credit-limited word memory with fixed read latency,
// in-order back-pressurable responses and flush.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = mem_pkg::LATENCY,
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int WORDS   = mem_pkg::WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy
);

    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int FW = $clog2(LATENCY + 1);

    logic [DATA_W-1:0] mem [WORDS];
    logic [IW-1:0]     idx;
    logic [CW-1:0]     credits;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              pop;
    rsp_t              entry;
    logic              push_v;
    rsp_t              push_d;
    rsp_t              head;
    rsp_t              last_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FW-1:0]     fifo_cnt;
    logic              unused_ok;

    // Credits bound pipe + FIFO occupancy, so the FIFO
    // can never overflow; ready never looks at requests.
    assign req_ready = rst_n & ~flush & (credits < CW'(LATENCY));
    assign accept    = req_valid & req_ready;
    assign wr_acc    = accept & req_wr;
    assign rd_acc    = accept & ~req_wr;
    assign idx       = req_addr[IW:1];
    assign entry     = '{addr: req_addr, data: mem[idx]};
    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready & ~flush;
    assign busy      = (credits != '0);
    assign unused_ok = ^{req_addr[0], fifo_full, fifo_cnt};

    // Word array; writes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[idx] <= req_wdata;
    end

    // Delay pipe: the FIFO push at the end of cycle
    // LATENCY-1 makes the head visible in cycle LATENCY.
    if (LATENCY == 1) begin : g_nopipe
        assign push_v = rd_acc;
        assign push_d = entry;
    end else begin : g_pipe
        logic pv [LATENCY-1];
        rsp_t pd [LATENCY-1];

        // Valid bits; flush squashes everything in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LATENCY - 1; i++) pv[i] <= 1'b0;
            end else if (flush) begin
                for (int i = 0; i < LATENCY - 1; i++) pv[i] <= 1'b0;
            end else begin
                pv[0] <= rd_acc;
                for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
            end
        end

        // Payload shift; qualified by the valid bits.
        always_ff @(posedge clk) begin
            pd[0] <= entry;
            for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
        end

        assign push_v = pv[LATENCY-2];
        assign push_d = pd[LATENCY-2];
    end

    rsp_fifo #(.DEPTH(LATENCY)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push_v),
        .din   (push_d),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outstanding-read credits: +1 accept, -1 pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else if (flush) begin
            credits <= '0;
        end else begin
            unique case ({rd_acc, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // Remember the last shown head so data stays put
    // after a pop until the next response arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (!fifo_empty) begin
            last_q <= head;
        end
    end

    assign rsp_rdata = fifo_empty ? last_q.data : head.data;
    assign rsp_addr  = fifo_empty ? last_q.addr : head.addr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a queue-based
// reference model checked on every falling edge.
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        flush = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic        busy;
    logic [15:0] rsp_rdata;
    logic [15:0] rsp_addr;

    mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cy;
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    ent_t        mq[$];
    ent_t        obs[$];
    logic [15:0] mm [int];
    bit          er;
    bit          ev;
    ent_t        e;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: pending reads each carry the cycle
    // they become due; responses leave strictly in order.
    always @(negedge clk) begin
        er = rst_n && !flush && (mq.size() < LAT);
        ev = 1'b0;
        if (rst_n && mq.size() > 0) ev = (mq[0].cy <= cyc);
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("busy", busy, rst_n && mq.size() != 0);
        if (ev) begin
            chk("rsp_rdata", rsp_rdata, mq[0].d);
            chk("rsp_addr", rsp_addr, mq[0].a);
        end else if (!rst_n) begin
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_addr", rsp_addr, 0);
        end
        if (rsp_valid && rsp_ready && rst_n && !flush) begin
            e.cy = cyc;
            e.a  = rsp_addr;
            e.d  = rsp_rdata;
            obs.push_back(e);
        end
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (ev && rsp_ready) void'(mq.pop_front());
            if (req_valid && er) begin
                if (req_wr) begin
                    mm[int'(req_addr[15:1])] = req_wdata;
                end else begin
                    e.cy = cyc + LAT;
                    e.a  = req_addr;
                    e.d  = mm.exists(int'(req_addr[15:1])) ?
                           mm[int'(req_addr[15:1])] : 16'hxxxx;
                    mq.push_back(e);
                end
            end
        end
        cyc++;
    end

    task automatic cycle_();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [15:0] a,
                          input logic [15:0] d);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        cycle_();
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 60) begin
            cycle_();
            n++;
        end
        if (mq.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d reads still pending", mq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data0", rsp_rdata, 0);
        repeat (3) cycle_();
        rst_n = 1'b1;
        #2 chk("ready_after_rst", req_ready, 1);
        cycle_();

        do_req(1'b1, 16'h0010, 16'h1234);
        n0 = obs.size();
        t0 = cyc;
        do_req(1'b0, 16'h0010, 16'h0);
        drain();
        chk("t1_count", obs.size() - n0, 1);
        if (obs.size() > n0) begin
            chk("t1_cycle", obs[n0].cy, t0 + LAT);
            chk("t1_data", obs[n0].d, 16'h1234);
            chk("t1_addr", obs[n0].a, 16'h0010);
        end

        for (int i = 0; i < 4; i++)
            do_req(1'b1, 16'(2 * i), 16'(16'hA0 + i));
        n0 = obs.size();
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            do_req(1'b0, 16'(2 * i), 16'h0);
        #2 chk("t2_ready_low", req_ready, 0);
        cycle_();
        #2 chk("t2_ready_back", req_ready, 1);
        drain();
        chk("t2_count", obs.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (obs.size() > n0 + i) begin
                chk("t2_cycle", obs[n0+i].cy, t0 + LAT + i);
                chk("t2_data", obs[n0+i].d, 16'hA0 + i);
                chk("t2_addr", obs[n0+i].a, 2 * i);
            end
        end

        rsp_ready = 1'b0;
        n0 = obs.size();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_wr    = 1'b0;
            req_addr  = 16'(2 * i);
            cycle_();
        end
        req_valid = 1'b0;
        #2 chk("t3_ready_low", req_ready, 0);
        chk("t3_pending", mq.size(), 4);
        repeat (3) cycle_();
        chk("t3_none_yet", obs.size() - n0, 0);
        rsp_ready = 1'b1;
        t0 = cyc;
        drain();
        chk("t3_count", obs.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (obs.size() > n0 + i) begin
                chk("t3_cycle", obs[n0+i].cy, t0 + i);
                chk("t3_data", obs[n0+i].d, 16'hA0 + i);
            end
        end

        n0 = obs.size();
        do_req(1'b0, 16'h0000, 16'h0);
        do_req(1'b0, 16'h0002, 16'h0);
        flush = 1'b1;
        #2 chk("t4_flush_ready", req_ready, 0);
        cycle_();
        flush = 1'b0;
        #2 chk("t4_busy", busy, 0);
        chk("t4_ready", req_ready, 1);
        repeat (10) cycle_();
        chk("t4_no_rsp", obs.size() - n0, 0);

        n0 = obs.size();
        do_req(1'b0, 16'h0000, 16'h0);
        do_req(1'b0, 16'h0002, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", rsp_valid, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rdata", rsp_rdata, 0);
        chk("t5_addr", rsp_addr, 0);
        cycle_();
        rst_n = 1'b1;
        do_req(1'b1, 16'h0100, 16'h5A5A);
        t0 = cyc;
        do_req(1'b0, 16'h0100, 16'h0);
        drain();
        chk("t5_count", obs.size() - n0, 1);
        if (obs.size() > n0) begin
            chk("t5_cycle", obs[n0].cy, t0 + LAT);
            chk("t5_data", obs[n0].d, 16'h5A5A);
            chk("t5_raddr", obs[n0].a, 16'h0100);
        end

        n0 = obs.size();
        do_req(1'b1, 16'h0011, 16'hBEEF);
        do_req(1'b0, 16'h0010, 16'h0);
        drain();
        chk("t6_count", obs.size() - n0, 1);
        if (obs.size() > n0) begin
            chk("t6_data", obs[n0].d, 16'hBEEF);
            chk("t6_addr", obs[n0].a, 16'h0010);
        end

        repeat (2) cycle_();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
